bounce_gen: RTL and testbench

- Synthesizable switch-bounce emulator, the source-side counterpart of the debouncer.
- Takes a clean, clk-synchronous level and produces a pseudo-random burst of toggles after each edge, then settles to the new level.
- Used in benches and in on-board self-test to drive debounce inputs without a physical button.
- The settled output is guaranteed within BOUNCE_TIME, so any debouncer with DELAY > BOUNCE_TIME yields exactly one clean transition per input edge.

---
 rtl/bounce_gen.sv | 106 ++++++++++
 tb/tb_bounce_gen.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bounce_gen.sv
// Switch-bounce emulator: turns clean level edges into a pseudo-random toggle burst that settles within BOUNCE_TIME.
// Optional isolated idle glitches are compiled in with `define BOUNCE_GEN_GLITCH_EN.
`timescale 1ns / 1ps
module bounce_gen #(
  parameter realtime     BOUNCE_TIME  = 5ms,
  parameter realtime     CLOCK_PERIOD = 20ns,
  parameter int          MIN_SEG      = 2,
  parameter int          SEG_BITS     = 4,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       signal_in,
  input  logic       enable,
  output logic       signal_out,
  output logic       bouncing,
  output logic [7:0] bounce_count
);

  localparam int          BOUNCE_CYCLES = int'(BOUNCE_TIME / CLOCK_PERIOD);
  localparam int          WIN_W         = $clog2(BOUNCE_CYCLES);
  localparam int          SEG_W         = $clog2(MIN_SEG + (1 << SEG_BITS));
  localparam logic [15:0] LFSR_INIT     = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [15:0] LFSR_MASK     = 16'hB400;

  typedef enum logic {IDLE, BOUNCE} state_t;

  state_t           state;
  logic             level_q;
  logic [15:0]      lfsr;
  logic [WIN_W-1:0] window;
  logic [SEG_W-1:0] seg;
  logic             edge_det;

  // Galois shift right; the taps never map a non-zero state to zero.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [SEG_W-1:0] seg_load(input logic [SEG_BITS-1:0] r);
    return SEG_W'(MIN_SEG) + SEG_W'(r);
  endfunction

  assign edge_det = (signal_in != level_q);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state        <= IDLE;
      level_q      <= 1'b0;
      signal_out   <= 1'b0;
      bouncing     <= 1'b0;
      bounce_count <= 8'd0;
      lfsr         <= LFSR_INIT;
      window       <= '0;
      seg          <= '0;
    end else begin
      lfsr <= lfsr_next(lfsr);
      if (!enable) begin
        // Pass-through; also aborts any burst in progress.
        state      <= IDLE;
        level_q    <= signal_in;
        signal_out <= signal_in;
        bouncing   <= 1'b0;
      end else if (edge_det) begin
        // First contact, or a retrigger that restarts the window.
        state        <= BOUNCE;
        level_q      <= signal_in;
        signal_out   <= signal_in;
        window       <= WIN_W'(BOUNCE_CYCLES - 1);
        seg          <= seg_load(lfsr[SEG_BITS-1:0]);
        bounce_count <= 8'd0;
        bouncing     <= 1'b1;
      end else if (state == IDLE) begin
`ifdef BOUNCE_GEN_GLITCH_EN
        if ((lfsr[15:8] == 8'h00) && (signal_out == level_q))
          signal_out <= ~level_q;
        else
          signal_out <= level_q;
`else
        signal_out <= level_q;
`endif
      end else if (window == '0) begin
        state      <= IDLE;
        signal_out <= level_q;
        bouncing   <= 1'b0;
      end else begin
        window <= window - WIN_W'(1);
        // Toggles stop once the window is nearly spent so the end restore stays clean.
        if (seg == '0) begin
          if (window > WIN_W'(1)) begin
            signal_out   <= ~signal_out;
            seg          <= seg_load(lfsr[SEG_BITS-1:0]);
            bounce_count <= sat_inc(bounce_count);
          end
        end else begin
          seg <= seg - SEG_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bounce_gen.sv
// Self-checking bench for bounce_gen: random and directed level changes checked against a window/toggle model.
`timescale 1ns / 1ps
module tb_bounce_gen;

  localparam int BC       = 100;
  localparam int MIN_SEG  = 2;
  localparam int SEG_BITS = 3;
  localparam int MAXG     = MIN_SEG + (1 << SEG_BITS);
  localparam int DB_DELAY = 200;

  logic       clk = 1'b0;
  logic       n_reset = 1'b1;
  logic       signal_in = 1'b0;
  logic       enable = 1'b1;
  logic       signal_out;
  logic       bouncing;
  logic [7:0] bounce_count;

  bounce_gen #(
    .BOUNCE_TIME (1us),
    .CLOCK_PERIOD(10ns),
    .MIN_SEG     (MIN_SEG),
    .SEG_BITS    (SEG_BITS)
  ) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .signal_in   (signal_in),
    .enable      (enable),
    .signal_out  (signal_out),
    .bouncing    (bouncing),
    .bounce_count(bounce_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: target level, remaining window samples, toggles seen, cycles since last toggle/edge.
  logic m_level;
  int   m_left, m_tog, gap;
  logic last_out;
  int   b_samples;
  int   step_no;
  // Behavioural debouncer fed from signal_out.
  logic db, db_prev;
  int   db_stable, db_trans, db_step;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_level  = 1'b0;
    m_left   = 0;
    m_tog    = 0;
    gap      = 0;
    last_out = 1'b0;
  endtask

  task automatic step();
    logic exp_out;
    logic known;
    @(posedge clk);
    #1;
    step_no++;
    known   = 1'b1;
    exp_out = 1'b0;
    if (!enable) begin
      m_level = signal_in;
      m_left  = 0;
      exp_out = signal_in;
    end else if (signal_in != m_level) begin
      m_level = signal_in;
      m_left  = BC;
      m_tog   = 0;
      gap     = 0;
      exp_out = signal_in;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        exp_out = m_level;
      end else begin
        known = 1'b0;
        gap++;
        if (signal_out !== last_out) begin
          chk("tog_gap", (gap > MIN_SEG) && (gap <= MAXG), 1);
          chk("tog_late", m_left >= 2, 1);
          if (m_tog < 255) m_tog++;
          gap = 0;
        end else if (m_left >= 2) begin
          chk("tog_due", gap < MAXG, 1);
        end
      end
    end else begin
      exp_out = m_level;
    end
    chk("bouncing", bouncing, m_left > 0);
    chk("bounce_count", bounce_count, m_tog);
    if (known) chk("signal_out", signal_out, exp_out);
    last_out = signal_out;
    if (bouncing) b_samples++;
    if (signal_out !== db_prev) db_stable = 0;
    else db_stable++;
    db_prev = signal_out;
    if (db_stable >= DB_DELAY && db != signal_out) begin
      db = signal_out;
      db_trans++;
      db_step = step_no;
    end
  endtask

  initial begin
    model_reset();
    b_samples = 0; step_no = 0;
    db = 1'b0; db_prev = 1'b0; db_stable = 0; db_trans = 0; db_step = 0;

    // Asynchronous reset before any clock edge.
    #2 n_reset = 1'b0;
    #1;
    chk("rst_out", signal_out, 0);
    chk("rst_bouncing", bouncing, 0);
    chk("rst_count", bounce_count, 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    n_reset = 1'b1;
    model_reset();

    // Quiet low input.
    repeat (150) step();

    // Rising edge, full burst.
    signal_in = 1'b1;
    b_samples = 0;
    repeat (200) step();
    chk("win_len", b_samples, BC);
    chk("cnt_ge1", bounce_count >= 8'd1, 1);

    // Retrigger 50 cycles into a burst.
    signal_in = 1'b0;
    repeat (150) step();
    signal_in = 1'b1;
    repeat (50) step();
    signal_in = 1'b0;
    b_samples = 0;
    repeat (200) step();
    chk("win_len_retrig", b_samples, BC);
    chk("retrig_final", signal_out, 0);

    // Abort a burst with enable=0, then pass-through toggling every 3 cycles.
    signal_in = 1'b1;
    repeat (30) step();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      repeat (3) step();
      signal_in = ~signal_in;
    end
    enable = 1'b1;
    repeat (150) step();

    // Randomized edges, retriggers and enable changes.
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(1, 150)) step();
      if ($urandom_range(0, 9) == 0) enable = ~enable;
      else signal_in = ~signal_in;
    end
    enable = 1'b1;
    repeat (150) step();

    // Chain into a debouncer with DELAY = 200 cycles.
    signal_in = 1'b0;
    repeat (150) step();
    db = signal_out; db_prev = signal_out; db_stable = 0;
    db_trans = 0; db_step = 0; step_no = 0;
    signal_in = 1'b1;
    repeat (400) step();
    chk("db_transitions", db_trans, 1);
    chk("db_level", db, 1);
    chk("db_in_time", db_step <= BC + DB_DELAY + 1, 1);

    // Reset 40 cycles into a burst, then restart with signal_in high.
    signal_in = 1'b0;
    repeat (150) step();
    signal_in = 1'b1;
    repeat (40) step();
    #3 n_reset = 1'b0;
    #1;
    chk("mid_rst_out", signal_out, 0);
    chk("mid_rst_bouncing", bouncing, 0);
    chk("mid_rst_count", bounce_count, 0);
    model_reset();
    @(negedge clk);
    n_reset = 1'b1;
    b_samples = 0;
    repeat (150) step();
    chk("post_rst_win_len", b_samples, BC);
    chk("post_rst_final", signal_out, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
